bin_to_bcd: RTL and testbench
=============================

BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 Parameter: BLINK_DIV, 25000000, OFF toggle period in CLK cycles while overflow blinks (used only when BIN_TO_BCD_BLINK_EN is defined).
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  conversion request; sampled only in IDLE.
REQ-005 BIN  input  6  binary score, 0..63, captured on an accepted START.
REQ-006 BUSY  output  1  high while a conversion is in progress.
REQ-007 DONE  output  1  single-cycle pulse when a new result is on the digit outputs.
REQ-008 DIGIT_H  output  2  BCD tens digit, 0..3.
REQ-009 DIGIT_L  output  4  BCD units digit, 0..9.
REQ-010 OFF  output  1  display blank request to the 7-segment driver, 1 = blank.
REQ-011 OVF  output  1  captured BIN exceeded 39.

Function
REQ-012 FSM states: IDLE, SHIFT; START=1 in IDLE shall capture BIN, clear the shift counter and enter SHIFT.
REQ-013 SHIFT shall perform one double-dabble step per cycle: add 3 to any BCD nibble >= 5, then shift left one bit with the next BIN MSB entering.
REQ-014 After exactly 6 SHIFT cycles, the FSM shall return to IDLE; DIGIT_H/DIGIT_L/OVF/OFF update on the same edge; DONE=1 for that one cycle.
REQ-015 Latency: START sampled at edge k -> DONE high and digits valid after edge k+6; BUSY high from after edge k through edge k+6.
REQ-016 START while BUSY=1 shall be ignored, with no queuing; START during the DONE cycle (FSM already in IDLE) shall be accepted.
REQ-017 Digit outputs shall hold the last result between conversions; intermediate shift values shall never appear on outputs.
REQ-018 Captured BIN > 39: OVF=1 and outputs saturate to DIGIT_H=3, DIGIT_L=9; otherwise OVF=0 and digits equal the exact decimal value.
REQ-019 The internal tens register is 3 bits wide, with no truncation during conversion; saturation is applied only on output load.
REQ-020 OFF=1 from reset until the first DONE; afterwards OFF=0, except as in REQ-025.

Reset
REQ-021 RESET=1 shall force, on the next edge: FSM=IDLE, BUSY=0, DONE=0, DIGIT_H=0, DIGIT_L=0, OVF=0, OFF=1, shift counter=0, blink counter=0.
REQ-022 RESET during SHIFT shall abort the conversion; no DONE pulse follows.
REQ-023 RESET has priority over START in the same cycle.

Configuration
REQ-024 Macro BIN_TO_BCD_BLINK_EN selects overflow blinking.
REQ-025 With the macro defined and OVF=1, a counter shall run 0..BLINK_DIV-1, and OFF shall toggle on each wrap; a DONE with OVF=0 forces OFF=0 and clears the counter; a DONE with OVF=1 restarts the counter with OFF=0.
REQ-026 Without the macro, no blink counter exists, and OFF follows REQ-020 only; OVF is still reported.

Structure
REQ-027 Package bin_to_bcd_pkg shall hold the FSM state typedef, BCD_MAX=39, BIN_W=6, the shift count 6 and the digit widths.
REQ-028 One combinational sub-module, dabble_step, shall implement the add-3/shift of REQ-013; the FSM, counters and output registers stay in bin_to_bcd.

Verification
REQ-029 Reset, then idle -> DIGIT_H=0, DIGIT_L=0, OFF=1, BUSY=0, DONE=0.
REQ-030 START with BIN=21 -> DONE exactly 6 cycles later, with DIGIT_H=2, DIGIT_L=1, OVF=0, OFF=0.
REQ-031 Sweep BIN=0..39, back-to-back STARTs issued in the DONE cycles -> every result is a correct decimal value and no START is lost.
REQ-032 BIN=45, then START pulsed again 3 cycles later -> second START ignored; result DIGIT_H=3, DIGIT_L=9, OVF=1; with BLINK_EN and BLINK_DIV=4, OFF toggles every 4 cycles until a START with BIN=10 completes (OFF=0).
REQ-033 START with BIN=37, then RESET asserted in the 3rd SHIFT cycle -> no DONE, and outputs equal the reset values of REQ-021.

Source files
------------

// File: rtl/bin_to_bcd_pkg.sv
// Shared widths, limits and FSM encoding for the 6-bit binary to 2-digit BCD converter.
package bin_to_bcd_pkg;

  localparam int BIN_W     = 6;
  localparam int BCD_MAX   = 39;
  localparam int SHIFT_N   = 6;
  localparam int DIGH_W    = 2;
  localparam int DIGL_W    = 4;
  localparam int TENS_W    = 3;
  localparam int SCNT_W    = 3;
  localparam int TENS_SAT  = BCD_MAX / 10;
  localparam int UNITS_SAT = BCD_MAX % 10;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Double-dabble correction: a nibble of 5 or more would exceed 9 after doubling.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin_to_bcd_dabble_step.sv
// One combinational double-dabble step: add-3 correction on each BCD nibble, then shift left with a new binary bit.
module dabble_step
  import bin_to_bcd_pkg::*;
(
  input  logic [TENS_W-1:0] tens,
  input  logic [3:0]        units,
  input  logic              bit_in,
  output logic [TENS_W+1:0] tens_next,
  output logic [3:0]        units_next
);

  logic [3:0] dig [2];
  logic [3:0] adj [2];

  assign dig[0] = units;
  assign dig[1] = {{(4 - TENS_W){1'b0}}, tens};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_adj
      assign adj[gi] = add3(dig[gi]);
    end
  endgenerate

  // The tens result keeps every bit so the caller can see values above the saturation limit.
  assign units_next = {adj[0][2:0], bit_in};
  assign tens_next  = {adj[1], adj[0][3]};

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential 6-bit binary to BCD converter with overflow saturation and display blanking.
// Optional overflow blinking of the blank request is enabled by defining BIN_TO_BCD_BLINK_EN.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int BLINK_DIV = 25000000
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BIN_W-1:0]  bin,
  output logic              busy,
  output logic              done,
  output logic [DIGH_W-1:0] digit_h,
  output logic [DIGL_W-1:0] digit_l,
  output logic              off,
  output logic              ovf
);

  state_t              state_reg;
  logic [SCNT_W-1:0]   shift_cnt_reg;
  logic [BIN_W-1:0]    bin_sh_reg;
  logic [TENS_W-1:0]   tens_reg;
  logic [DIGL_W-1:0]   units_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                off_reg;
  logic                ovf_reg;
  logic [DIGH_W-1:0]   digit_h_reg;
  logic [DIGL_W-1:0]   digit_l_reg;

  logic [TENS_W+1:0]   step_tens;
  logic [DIGL_W-1:0]   step_units;
  logic                step_ovf;
  logic                last_step;
  logic                blink_wrap;

  generate
    if (BLINK_DIV < 1) begin : g_blink_div_check
      $error("BLINK_DIV must be at least 1");
    end
  endgenerate

  dabble_step u_step (
    .tens       (tens_reg),
    .units      (units_reg),
    .bit_in     (bin_sh_reg[BIN_W-1]),
    .tens_next  (step_tens),
    .units_next (step_units)
  );

  assign step_ovf  = step_tens > (TENS_W + 2)'(TENS_SAT);
  assign last_step = (state_reg == SHIFT) && (shift_cnt_reg == SCNT_W'(SHIFT_N - 1));

`ifdef BIN_TO_BCD_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt_reg;

  assign blink_wrap = ovf_reg && !last_step && (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1));

  // Runs only while an overflow result is on display; every result load restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_reg <= '0;
    end else if (last_step) begin
      blink_cnt_reg <= '0;
    end else if (ovf_reg) begin
      if (blink_wrap) begin
        blink_cnt_reg <= '0;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end
`else
  assign blink_wrap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      shift_cnt_reg <= '0;
      bin_sh_reg    <= '0;
      tens_reg      <= '0;
      units_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      off_reg       <= 1'b1;
      ovf_reg       <= 1'b0;
      digit_h_reg   <= '0;
      digit_l_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      if (blink_wrap) begin
        off_reg <= !off_reg;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            bin_sh_reg    <= bin;
            tens_reg      <= '0;
            units_reg     <= '0;
            shift_cnt_reg <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= SHIFT;
          end
        end
        SHIFT: begin
          bin_sh_reg    <= bin_sh_reg << 1;
          tens_reg      <= step_tens[TENS_W-1:0];
          units_reg     <= step_units;
          shift_cnt_reg <= shift_cnt_reg + 1'b1;
          // Only the final step reaches the outputs, so partial values never show.
          if (last_step) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            off_reg   <= 1'b0;
            ovf_reg   <= step_ovf;
            if (step_ovf) begin
              digit_h_reg <= DIGH_W'(TENS_SAT);
              digit_l_reg <= DIGL_W'(UNITS_SAT);
            end else begin
              digit_h_reg <= step_tens[DIGH_W-1:0];
              digit_l_reg <= step_units;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign digit_h = digit_h_reg;
  assign digit_l = digit_l_reg;
  assign off     = off_reg;
  assign ovf     = ovf_reg;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed scenarios plus random traffic against a decimal-arithmetic model.
module tb_bin_to_bcd;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] bin = '0;
  logic       busy, done, off, ovf;
  logic [1:0] digit_h;
  logic [3:0] digit_l;

  int checks = 0;
  int failures = 0;

  bin_to_bcd #(.BLINK_DIV(DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .digit_h (digit_h),
    .digit_l (digit_l),
    .off     (off),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish got=running want=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a conversion is just "value appears 6 edges after acceptance", as decimal digits.
  bit m_valid = 1'b0;
  bit m_busy, m_done, m_ovf, m_off, m_loaded;
  int m_cnt, m_val, m_h, m_l, m_blink;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_busy = 0; m_done = 0; m_ovf = 0; m_off = 1;
      m_cnt = 0; m_h = 0; m_l = 0; m_blink = 0; m_val = 0;
    end else if (m_valid) begin
      m_loaded = 0;
      m_done = 0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == 6) begin
          m_busy = 0;
          m_done = 1;
          m_loaded = 1;
          m_ovf = (m_val > 39);
          m_h = m_ovf ? 3 : m_val / 10;
          m_l = m_ovf ? 9 : m_val % 10;
          m_off = 0;
          m_blink = 0;
        end
      end else if (start) begin
        m_busy = 1;
        m_cnt = 0;
        m_val = int'(bin);
      end
`ifdef BIN_TO_BCD_BLINK_EN
      if (!m_loaded && m_ovf) begin
        if (m_blink == DIV - 1) begin
          m_blink = 0;
          m_off = !m_off;
        end else begin
          m_blink++;
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("digit_h", 32'(digit_h), 32'(m_h));
      chk("digit_l", 32'(digit_l), 32'(m_l));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("off", 32'(off), 32'(m_off));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n, input int maxc);
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < maxc);
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
  endtask

  initial begin
    int n;
    int ndone;
    int dones;

    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_digit_h", 32'(digit_h), 0);
    chk("rst_digit_l", 32'(digit_l), 0);
    chk("rst_off", 32'(off), 1);
    chk("rst_ovf", 32'(ovf), 0);

    // BIN=21: latency and digits
    start = 1'b1; bin = 6'd21;
    tick();
    start = 1'b0;
    wait_done(n, 20);
    chk("lat21", n, 6);
    chk("bin21_h", 32'(digit_h), 2);
    chk("bin21_l", 32'(digit_l), 1);
    chk("bin21_ovf", 32'(ovf), 0);
    chk("bin21_off", 32'(off), 0);
    $display("txn bin=21 latency=%0d digits=%0d%0d ovf=%0d", n, digit_h, digit_l, ovf);

    // Back-to-back sweep with each START issued in the DONE cycle
    repeat (2) tick();
    start = 1'b1; bin = 6'd0;
    ndone = 0;
    for (int v = 0; v < 40; v++) begin
      tick();
      start = 1'b0;
      wait_done(n, 12);
      if (done === 1'b1) ndone++;
      chk("sweep_lat", n, 6);
      chk("sweep_h", 32'(digit_h), 32'(v / 10));
      chk("sweep_l", 32'(digit_l), 32'(v % 10));
      $display("txn sweep bin=%0d digits=%0d%0d", v, digit_h, digit_l);
      if (v < 39) begin
        start = 1'b1;
        bin = 6'(v + 1);
      end
    end
    chk("sweep_count", ndone, 40);

    // Overflow with an ignored START while busy
    repeat (2) tick();
    start = 1'b1; bin = 6'd45;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1; bin = 6'd5;
    tick();
    start = 1'b0;
    wait_done(n, 12);
    chk("ovf45_lat_rest", n, 3);
    chk("ovf45_h", 32'(digit_h), 3);
    chk("ovf45_l", 32'(digit_l), 9);
    chk("ovf45_ovf", 32'(ovf), 1);
    $display("txn bin=45 digits=%0d%0d ovf=%0d", digit_h, digit_l, ovf);
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    chk("ignored_start_no_done", dones, 0);
    start = 1'b1; bin = 6'd10;
    tick();
    start = 1'b0;
    wait_done(n, 12);
    chk("bin10_h", 32'(digit_h), 1);
    chk("bin10_l", 32'(digit_l), 0);
    chk("bin10_ovf", 32'(ovf), 0);
    chk("bin10_off", 32'(off), 0);
    $display("txn bin=10 digits=%0d%0d off=%0d", digit_h, digit_l, off);

    // Reset during the third SHIFT cycle aborts the conversion
    tick();
    start = 1'b1; bin = 6'd37;
    tick();
    start = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_h", 32'(digit_h), 0);
    chk("abort_l", 32'(digit_l), 0);
    chk("abort_off", 32'(off), 1);
    chk("abort_ovf", 32'(ovf), 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 0);
    $display("txn bin=37 aborted by reset dones=%0d", dones);

    // Random traffic, model-checked every cycle
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 2) == 0);
      bin = 6'($urandom_range(0, 63));
      reset = ($urandom_range(0, 59) == 0);
      tick();
      if (done === 1'b1) $display("txn random digits=%0d%0d ovf=%0d", digit_h, digit_l, ovf);
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
